prog_rom: RTL and testbench

PROG_ROM -- requirements
Module: prog_rom

---
 rtl/prog_rom_pkg.sv | 28 ++
 rtl/prog_rom_array.sv | 46 ++++
 rtl/prog_rom.sv | 153 +++++++++++++++
 tb/tb_prog_rom.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_rom_pkg.sv
// -----------------------------------------------------------------------------
// prog_rom_pkg
// Shared definitions for the program ROM: the load/fetch FSM state encoding,
// the NOP instruction word returned for unloaded locations, and the opcode
// values that occupy the top four bits of each instruction word.
// -----------------------------------------------------------------------------
package prog_rom_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // All-zero word: opcode 0 is not a defined operation, so it decodes as NOP.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SL  = 4'd2;
  localparam logic [3:0] OP_SR  = 4'd3;
  localparam logic [3:0] OP_LI  = 4'd4;
  localparam logic [3:0] OP_LD  = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_ST  = 4'd7;
  localparam logic [3:0] OP_BR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;

endpackage

// File: rtl/prog_rom_array.sv
// -----------------------------------------------------------------------------
// prog_rom_array
// Instruction storage: one synchronous write port and one registered read port.
// The storage array itself is never reset; only the read register is.
//
// Ports
//   clk      in   clock (rising edge)
//   reset_n  in   asynchronous active-low reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable; read register holds when low
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module prog_rom_array #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_rom.sv
// -----------------------------------------------------------------------------
// prog_rom
// Loadable program ROM. A program is streamed in through the load port
// (EMPTY -> LOAD -> READY); once READY, instructions are fetched with a
// one-cycle latency. Locations not written during the current load read as NOP.
//
// Build option: define PROG_ROM_PARITY_EN to store an even-parity bit with every
// word and flag mismatches on rd_err. Without it rd_err is tied low.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   chip_select  in   enables the fetch port
//   rd_en        in   fetch request
//   address      in   fetch address
//   data_out     out  fetched instruction (held between fetches)
//   rd_valid     out  data_out valid this cycle
//   rd_err       out  parity error on current data_out
//   ld_start     in   begin or restart program load
//   ld_valid     in   load word offered
//   ld_data      in   load word
//   ld_last      in   marks final load word
//   ld_ready     out  load word accepted when ld_valid is high
//   ready        out  program loaded; fetch port enabled
// -----------------------------------------------------------------------------
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chip_select,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef PROG_ROM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DEPTH-1:0]  r_loaded;
  logic              r_ld_ready;
  logic              r_ready;
  logic              r_rd_valid;
  logic              r_rd_loaded;

  logic              w_accept;
  logic              w_ld_done;
  logic              w_fetch;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rd_word;

  // ld_start wins over a coincident load word, so that word is never written.
  assign w_accept  = (r_state == ST_LOAD) && ld_valid && !ld_start;
  assign w_ld_done = w_accept && (ld_last || (r_ptr == LAST_ADDR));
  assign w_fetch   = (r_state == ST_READY) && chip_select && rd_en;

`ifdef PROG_ROM_PARITY_EN
  // Even parity: the stored word including the parity bit XORs to zero.
  assign w_wdata = {^ld_data, ld_data};
`else
  assign w_wdata = ld_data;
`endif

  // ld_ready/ready are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= '0;
      r_loaded   <= '0;
      r_ld_ready <= 1'b0;
      r_ready    <= 1'b0;
    end else if (ld_start) begin
      r_state    <= ST_LOAD;
      r_ptr      <= '0;
      r_loaded   <= '0;
      r_ld_ready <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_loaded[r_ptr] <= 1'b1;
            // Pointer saturates at the top location instead of wrapping.
            if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + 1'b1;
            if (w_ld_done) begin
              r_state    <= ST_READY;
              r_ld_ready <= 1'b0;
              r_ready    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch side: the loaded flag is captured at request time, so a fetch that
  // overlaps ld_start still returns the word as it stood when requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_loaded <= 1'b0;
    end else begin
      r_rd_valid <= w_fetch;
      if (w_fetch) r_rd_loaded <= r_loaded[address];
    end
  end

  prog_rom_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_accept),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch),
    .i_raddr (address),
    .o_rdata (w_rd_word)
  );

  assign data_out = r_rd_loaded ? w_rd_word[DATA_W-1:0] : DATA_W'(NOP_WORD);
  assign rd_valid = r_rd_valid;
  assign ld_ready = r_ld_ready;
  assign ready    = r_ready;

`ifdef PROG_ROM_PARITY_EN
  assign rd_err = r_rd_valid && r_rd_loaded && (^w_rd_word);
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_rom.sv
module tb_prog_rom;
  import prog_rom_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset_n;
  logic              chip_select;
  logic              rd_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_err;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] prog [4];

  prog_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chip_select (chip_select),
    .rd_en       (rd_en),
    .address     (address),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    prog[0] = {OP_LI, 28'h000000F};
    prog[1] = {OP_ST, 28'h000005F};
    prog[2] = {OP_LI, 28'h0000001};
    prog[3] = {OP_ADD, 28'h000005F};

    reset_n = 1'b0; chip_select = 1'b0; rd_en = 1'b0; address = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    reset_n = 1'b1;
    tick();

    // Fetch while EMPTY is ignored.
    chip_select = 1'b1; rd_en = 1'b1; address = 5'd0;
    tick();
    chk("empty_ready", 32'(ready), 32'd0);
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_data_out", data_out, 32'h0);
    tick();
    chk("empty_rd_valid2", 32'(rd_valid), 32'd0);
    chip_select = 1'b0; rd_en = 1'b0;

    // Four-word program, last word flagged.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("load_ld_ready", 32'(ld_ready), 32'd1);
    chk("load_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 3);
      chk($sformatf("load4_ld_ready_%0d", i), 32'(ld_ready), 32'd1);
      chk($sformatf("load4_ready_%0d", i), 32'(ready), 32'd0);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    tick();
    chk("load4_ready_after", 32'(ready), 32'd1);
    chk("load4_ld_ready_after", 32'(ld_ready), 32'd0);

    // Fetch address 3.
    chip_select = 1'b1; rd_en = 1'b1; address = 5'd3;
    chk("fetch3_pre_valid", 32'(rd_valid), 32'd0);
    tick();
    chip_select = 1'b0; rd_en = 1'b0;
    chk("fetch3_valid", 32'(rd_valid), 32'd1);
    chk("fetch3_data", data_out, 32'h1000005F);
    chk("fetch3_err", 32'(rd_err), 32'd0);
    tick();
    chk("fetch3_valid_drop", 32'(rd_valid), 32'd0);
    chk("fetch3_data_held", data_out, 32'h1000005F);

    // Unloaded location returns NOP.
    chip_select = 1'b1; rd_en = 1'b1; address = 5'h14;
    tick();
    chip_select = 1'b0; rd_en = 1'b0;
    chk("fetch14_valid", 32'(rd_valid), 32'd1);
    chk("fetch14_data", data_out, 32'h0);
    chk("fetch14_err", 32'(rd_err), 32'd0);

    // Back-to-back fetches 0,1,2.
    chip_select = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = 5'(i);
      tick();
      chk($sformatf("b2b_valid_%0d", i), 32'(rd_valid), 32'd1);
      chk($sformatf("b2b_data_%0d", i), data_out, prog[i]);
    end
    chip_select = 1'b0; rd_en = 1'b0;
    tick();
    chk("b2b_valid_end", 32'(rd_valid), 32'd0);

    // Full 32-word load without ld_last; ld_valid stays high afterwards.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = 32'h5A5A0000 | 32'(i);
      chk($sformatf("load32_ld_ready_%0d", i), 32'(ld_ready), 32'd1);
      tick();
    end
    ld_data = 32'hDEADBEEF;
    tick();
    chk("load32_ready", 32'(ready), 32'd1);
    chk("load32_ld_ready_after", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    chip_select = 1'b1; rd_en = 1'b1; address = 5'd31;
    tick();
    chk("load32_fetch31", data_out, 32'h5A5A001F);
    address = 5'd0;
    tick();
    chk("load32_fetch0", data_out, 32'h5A5A0000);
    chk("load32_fetch0_valid", 32'(rd_valid), 32'd1);

    // ld_start during a fetch of address 1: fetch completes.
    address = 5'd1; ld_start = 1'b1;
    tick();
    ld_start = 1'b0; chip_select = 1'b0; rd_en = 1'b0;
    chk("restart_fetch_valid", 32'(rd_valid), 32'd1);
    chk("restart_fetch_data", data_out, 32'h5A5A0001);
    chk("restart_ready", 32'(ready), 32'd0);
    chk("restart_ld_ready", 32'(ld_ready), 32'd1);

    // Fetch during LOAD is ignored, data_out held.
    chip_select = 1'b1; rd_en = 1'b1; address = 5'd0;
    tick();
    chip_select = 1'b0; rd_en = 1'b0;
    chk("loadfetch_valid", 32'(rd_valid), 32'd0);
    chk("loadfetch_held", data_out, 32'h5A5A0001);

    // ld_start with ld_valid: word dropped, pointer restarts at 0.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'h11111111;
    tick();
    ld_start = 1'b0; ld_data = 32'h80000000; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("reload_ready", 32'(ready), 32'd1);
    chip_select = 1'b1; rd_en = 1'b1; address = 5'd1;
    tick();
    chk("reload_fetch1", data_out, 32'h0);
    chk("reload_fetch1_valid", 32'(rd_valid), 32'd1);
    address = 5'd0;
    tick();
    chk("reload_fetch0", data_out, 32'h80000000);
    address = 5'd31;
    tick();
    chk("reload_fetch31", data_out, 32'h0);
    chip_select = 1'b0; rd_en = 1'b0;
    tick();

    // Reset mid-operation clears outputs and returns to EMPTY.
    reset_n = 1'b0;
    #2;
    chk("areset_ready", 32'(ready), 32'd0);
    chk("areset_data_out", data_out, 32'h0);
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
